rob_mc: RTL

Parametrised multi-commit reorder buffer, successor to the single-commit ROB. It sits between rename/dispatch and the RRF. It accepts one dispatched instruction per cycle and marks entries done from NUM_CDB completion buses. It retires up to COMMIT_WIDTH entries per cycle in program order, and performs a full flush when a mispredicted branch reaches commit.

---
 rtl/rob_mc_pkg.sv | 22 ++
 rtl/rob_mc_if.sv | 53 +++++
 rtl/rob_mc_commit_sel.sv | 39 +++
 rtl/rob_mc.sv | 112 +++++++++++
 4 files changed

// File: rtl/rob_mc_pkg.sv
// Shared types for the multi-commit reorder buffer: per-entry storage and per-lane commit payload.
package rv32i_types;

    localparam int ROB_PREG_W = 6;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  mispred;
        logic [31:0]           target;
        logic [ROB_PREG_W-1:0] pd;
        logic [4:0]            rd;
        logic [31:0]           pc;
    } rob_mc_entry_t;

    typedef struct packed {
        logic [ROB_PREG_W-1:0] pd;
        logic [4:0]            rd;
        logic [31:0]           pc;
    } rob_commit_t;

endpackage

// File: rtl/rob_mc_if.sv
// Dispatch / completion / retire bundle of rob_mc; commit_order exists only when ROB_RVFI_EN is defined.
interface rob_mc_if #(
    parameter int DEPTH        = 64,
    parameter int NUM_CDB      = 3,
    parameter int COMMIT_WIDTH = 2,
    parameter int PREG_W       = 6
);
    localparam int IDX_W = $clog2(DEPTH);

    logic                         enq_valid;
    logic                         enq_ready;
    logic [PREG_W-1:0]            enq_pd;
    logic [4:0]                   enq_rd;
    logic [31:0]                  enq_pc;
    logic [IDX_W-1:0]             enq_idx;
    logic [NUM_CDB-1:0]           cdb_valid;
    logic [NUM_CDB*IDX_W-1:0]     cdb_idx;
    logic [NUM_CDB-1:0]           cdb_mispred;
    logic [NUM_CDB*32-1:0]        cdb_target;
    logic [COMMIT_WIDTH-1:0]      commit_valid;
    logic [COMMIT_WIDTH*PREG_W-1:0] commit_pd;
    logic [COMMIT_WIDTH*5-1:0]    commit_rd;
    logic [COMMIT_WIDTH*32-1:0]   commit_pc;
    logic                         flush;
    logic [31:0]                  flush_pc;
    logic [IDX_W:0]               count;
`ifdef ROB_RVFI_EN
    logic [COMMIT_WIDTH*64-1:0]   commit_order;
`endif

    modport slave (
        input  enq_valid, enq_pd, enq_rd, enq_pc,
        input  cdb_valid, cdb_idx, cdb_mispred, cdb_target,
        output enq_ready, enq_idx,
        output commit_valid, commit_pd, commit_rd, commit_pc,
`ifdef ROB_RVFI_EN
        output commit_order,
`endif
        output flush, flush_pc, count
    );

    modport master (
        output enq_valid, enq_pd, enq_rd, enq_pc,
        output cdb_valid, cdb_idx, cdb_mispred, cdb_target,
        input  enq_ready, enq_idx,
        input  commit_valid, commit_pd, commit_rd, commit_pc,
`ifdef ROB_RVFI_EN
        input  commit_order,
`endif
        input  flush, flush_pc, count
    );

endinterface

// File: rtl/rob_mc_commit_sel.sv
// Combinational retire selection over the head window: in-order prefix of done entries,
// stopping after the first mispredicted branch, which also raises flush.
module rob_commit_sel
    import rv32i_types::*;
#(
    parameter int COMMIT_WIDTH = 2,
    localparam int CNT_W       = $clog2(COMMIT_WIDTH + 1)
) (
    input  rob_mc_entry_t           window [COMMIT_WIDTH],
    output logic [COMMIT_WIDTH-1:0] lane_valid,
    output logic [CNT_W-1:0]        retire_cnt,
    output logic                    flush,
    output logic [31:0]             flush_pc
);

    logic blocked;

    always_comb begin
        lane_valid = '0;
        retire_cnt = '0;
        flush      = 1'b0;
        flush_pc   = '0;
        blocked    = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (!blocked && window[i].valid && window[i].done) begin
                lane_valid[i] = 1'b1;
                retire_cnt    = retire_cnt + CNT_W'(1);
                if (window[i].mispred) begin
                    flush    = 1'b1;
                    flush_pc = window[i].target;
                    blocked  = 1'b1;
                end
            end else begin
                blocked = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_mc.sv
// Multi-commit reorder buffer: one dispatch per cycle, NUM_CDB completions, up to COMMIT_WIDTH
// in-order retirements, full flush on a retiring mispredict. ROB_RVFI_EN adds the commit_order counter.
module rob_mc
    import rv32i_types::*;
#(
    parameter int DEPTH        = 64,
    parameter int NUM_CDB      = 3,
    parameter int COMMIT_WIDTH = 2,
    parameter int PREG_W       = ROB_PREG_W
) (
    input logic     clk,
    input logic     rst_n,
    rob_mc_if.slave rob
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(COMMIT_WIDTH + 1);

    rob_mc_entry_t           entries [DEPTH];
    rob_mc_entry_t           window  [COMMIT_WIDTH];
    rob_commit_t             lanes   [COMMIT_WIDTH];
    logic [IDX_W-1:0]        win_idx [COMMIT_WIDTH];
    logic [PTR_W-1:0]        head, tail;
    logic [COMMIT_WIDTH-1:0] lane_valid;
    logic [CNT_W-1:0]        retire_cnt;
    logic                    full, flush, enq_fire;
    logic [31:0]             flush_pc;

    assign full     = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
    assign enq_fire = rob.enq_valid && rob.enq_ready;

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            win_idx[i]   = head[IDX_W-1:0] + IDX_W'(i);
            window[i]    = entries[win_idx[i]];
            lanes[i].pd  = window[i].pd;
            lanes[i].rd  = window[i].rd;
            lanes[i].pc  = window[i].pc;
        end
    end

    rob_commit_sel #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_sel (
        .window     (window),
        .lane_valid (lane_valid),
        .retire_cnt (retire_cnt),
        .flush      (flush),
        .flush_pc   (flush_pc)
    );

    assign rob.enq_ready    = !full && !flush;
    assign rob.enq_idx      = tail[IDX_W-1:0];
    assign rob.count        = tail - head;
    assign rob.commit_valid = lane_valid;
    assign rob.flush        = flush;
    assign rob.flush_pc     = flush_pc;

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            rob.commit_pd[i*PREG_W +: PREG_W] = PREG_W'(lanes[i].pd);
            rob.commit_rd[i*5 +: 5]           = lanes[i].rd;
            rob.commit_pc[i*32 +: 32]         = lanes[i].pc;
        end
    end

    // Completions are applied before retire clears so a same-cycle retire wins on valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
            head <= head + PTR_W'(retire_cnt);
            tail <= head + PTR_W'(retire_cnt);
        end else begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (rob.cdb_valid[k] && entries[rob.cdb_idx[k*IDX_W +: IDX_W]].valid) begin
                    entries[rob.cdb_idx[k*IDX_W +: IDX_W]].done    <= 1'b1;
                    entries[rob.cdb_idx[k*IDX_W +: IDX_W]].mispred <= rob.cdb_mispred[k];
                    entries[rob.cdb_idx[k*IDX_W +: IDX_W]].target  <= rob.cdb_target[k*32 +: 32];
                end
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (lane_valid[i]) entries[win_idx[i]].valid <= 1'b0;
            end
            if (enq_fire) begin
                entries[tail[IDX_W-1:0]] <= '{valid: 1'b1, done: 1'b0, mispred: 1'b0, target: 32'h0,
                                              pd: ROB_PREG_W'(rob.enq_pd), rd: rob.enq_rd, pc: rob.enq_pc};
                tail <= tail + PTR_W'(1);
            end
            head <= head + PTR_W'(retire_cnt);
        end
    end

`ifdef ROB_RVFI_EN
    logic [63:0] retire_order;

    // Keeps counting through flushes; only reset returns it to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) retire_order <= '0;
        else        retire_order <= retire_order + 64'(retire_cnt);
    end

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            rob.commit_order[i*64 +: 64] = retire_order + 64'(i);
        end
    end
`endif

endmodule
